// File: rtl/y86_pkg.sv
// Shared Y86 pipeline definitions: status/instruction codes, stage bundle
// layouts and the NOP bubble value loaded into each pipeline register.
package y86_pkg;

    localparam logic [1:0] AOK = 2'b11;
    localparam logic [1:0] HLT = 2'b10;
    localparam logic [1:0] ADR = 2'b01;
    localparam logic [1:0] INS = 2'b00;

    localparam logic [3:0] ICODE_NOP = 4'h1;
    localparam logic [3:0] RNONE     = 4'hF;

    localparam int D_W = 146;
    localparam int E_W = 218;
    localparam int M_W = 143;
    localparam int W_W = 142;

    // Field LSB positions; each bundle is packed MSB-first starting with stat.
    localparam int D_STAT_LSB  = 144;
    localparam int D_ICODE_LSB = 140;
    localparam int D_IFUN_LSB  = 136;
    localparam int D_RA_LSB    = 132;
    localparam int D_RB_LSB    = 128;
    localparam int D_VALC_LSB  = 64;
    localparam int D_VALP_LSB  = 0;

    localparam int E_STAT_LSB  = 216;
    localparam int E_ICODE_LSB = 212;
    localparam int E_IFUN_LSB  = 208;
    localparam int E_VALC_LSB  = 144;
    localparam int E_VALA_LSB  = 80;
    localparam int E_VALB_LSB  = 16;
    localparam int E_DSTE_LSB  = 12;
    localparam int E_DSTM_LSB  = 8;
    localparam int E_SRCA_LSB  = 4;
    localparam int E_SRCB_LSB  = 0;

    localparam int M_STAT_LSB  = 141;
    localparam int M_ICODE_LSB = 137;
    localparam int M_CND_LSB   = 136;
    localparam int M_VALE_LSB  = 72;
    localparam int M_VALA_LSB  = 8;
    localparam int M_DSTE_LSB  = 4;
    localparam int M_DSTM_LSB  = 0;

    localparam int W_STAT_LSB  = 140;
    localparam int W_ICODE_LSB = 136;
    localparam int W_VALE_LSB  = 72;
    localparam int W_VALM_LSB  = 8;
    localparam int W_DSTE_LSB  = 4;
    localparam int W_DSTM_LSB  = 0;

    localparam logic [D_W-1:0] D_BUBBLE = {AOK, ICODE_NOP, 4'h0, RNONE, RNONE, 64'h0, 64'h0};
    localparam logic [E_W-1:0] E_BUBBLE = {AOK, ICODE_NOP, 4'h0, 64'h0, 64'h0, 64'h0,
                                           RNONE, RNONE, RNONE, RNONE};
    localparam logic [M_W-1:0] M_BUBBLE = {AOK, ICODE_NOP, 1'b0, 64'h0, 64'h0, RNONE, RNONE};
    localparam logic [W_W-1:0] W_BUBBLE = {AOK, ICODE_NOP, 64'h0, 64'h0, RNONE, RNONE};

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } run_state_t;

endpackage

// File: rtl/pipe_reg.sv
// One pipeline register: stall holds, bubble injects the NOP value, otherwise loads d.
// The bubble value doubles as the reset value.
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall,
    input  logic         bubble,
    input  logic [W-1:0] bubble_val,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= bubble_val;
        else if (stall)
            q <= q;
        else if (bubble)
            q <= bubble_val;
        else
            q <= d;
    end

endmodule

// File: rtl/pipe_stage_regs.sv
// F/D/E/M/W pipeline registers driven by the hazard-control unit, with sticky
// halt on a non-AOK writeback, illegal-control flag and stall/bubble counters.
module pipe_stage_regs
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             F_stall,
    input  logic             D_stall,
    input  logic             D_bubble,
    input  logic             E_bubble,
    input  logic             M_bubble,
    input  logic             W_stall,
    input  logic [63:0]      f_predPC,
    input  logic [D_W-1:0]   d_next,
    input  logic [E_W-1:0]   e_next,
    input  logic [M_W-1:0]   m_next,
    input  logic [W_W-1:0]   w_next,
    output logic [63:0]      F_predPC,
    output logic [D_W-1:0]   D_q,
    output logic [E_W-1:0]   E_q,
    output logic [M_W-1:0]   M_q,
    output logic [W_W-1:0]   W_q,
    output logic             halted,
    output logic             ctrl_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt
);

    run_state_t state, state_nxt;
    logic       frozen;
    logic       illegal;
    logic       any_bubble;
    logic       halt_now;

    assign frozen     = (state == HALT);
    assign any_bubble = D_bubble | E_bubble | M_bubble;
    assign illegal    = (D_stall & D_bubble) | (F_stall & ~D_stall & ~D_bubble);
    // Only a bundle that W actually loads can halt the core.
    assign halt_now   = ~frozen & ~W_stall & (w_next[W_STAT_LSB +: 2] != AOK);
    assign halted     = frozen;

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (halt_now) state_nxt = HALT;
            HALT:    state_nxt = HALT;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            ctrl_err <= 1'b0;
        else if (illegal)
            ctrl_err <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (!frozen) begin
            if (F_stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (any_bubble)
                bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    pipe_reg #(.W(64)) u_f (
        .clk        (clk),
        .rst        (rst),
        .stall      (F_stall | frozen),
        .bubble     (1'b0),
        .bubble_val (RESET_PC),
        .d          (f_predPC),
        .q          (F_predPC)
    );

    pipe_reg #(.W(D_W)) u_d (
        .clk        (clk),
        .rst        (rst),
        .stall      (D_stall | frozen),
        .bubble     (D_bubble),
        .bubble_val (D_BUBBLE),
        .d          (d_next),
        .q          (D_q)
    );

    pipe_reg #(.W(E_W)) u_e (
        .clk        (clk),
        .rst        (rst),
        .stall      (frozen),
        .bubble     (E_bubble),
        .bubble_val (E_BUBBLE),
        .d          (e_next),
        .q          (E_q)
    );

    pipe_reg #(.W(M_W)) u_m (
        .clk        (clk),
        .rst        (rst),
        .stall      (frozen),
        .bubble     (M_bubble),
        .bubble_val (M_BUBBLE),
        .d          (m_next),
        .q          (M_q)
    );

    pipe_reg #(.W(W_W)) u_w (
        .clk        (clk),
        .rst        (rst),
        .stall      (W_stall | frozen),
        .bubble     (1'b0),
        .bubble_val (W_BUBBLE),
        .d          (w_next),
        .q          (W_q)
    );

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Scoreboard bench for pipe_stage_regs: directed hazard scenarios plus random
// control/data, checked against a cycle-level behavioural model of the stage rules.
module tb_pipe_stage_regs;

    localparam logic [63:0] RST_PC = 64'h0000_0000_0000_1000;
    localparam int          CW     = 4;

    localparam logic [145:0] D_NOP = {2'b11, 4'h1, 4'h0, 8'hFF, 128'h0};
    localparam logic [217:0] E_NOP = {2'b11, 4'h1, 4'h0, 192'h0, 16'hFFFF};
    localparam logic [142:0] M_NOP = {2'b11, 4'h1, 1'b0, 128'h0, 8'hFF};
    localparam logic [141:0] W_NOP = {2'b11, 4'h1, 128'h0, 8'hFF};

    typedef struct packed {
        logic         rst, fs, ds, db, eb, mb, ws;
        logic [63:0]  pc;
        logic [145:0] dn;
        logic [217:0] en;
        logic [142:0] mn;
        logic [141:0] wn;
    } stim_t;

    typedef struct packed {
        logic [63:0]  pc;
        logic [145:0] d;
        logic [217:0] e;
        logic [142:0] m;
        logic [141:0] w;
        logic         halted, err;
        logic [CW-1:0] sc, bc;
    } snap_t;

    logic          clk;
    logic          rst, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;
    logic [63:0]   f_predPC;
    logic [145:0]  d_next;
    logic [217:0]  e_next;
    logic [142:0]  m_next;
    logic [141:0]  w_next;
    logic [63:0]   F_predPC;
    logic [145:0]  D_q;
    logic [217:0]  E_q;
    logic [142:0]  M_q;
    logic [141:0]  W_q;
    logic          halted, ctrl_err;
    logic [CW-1:0] stall_cnt, bubble_cnt;

    pipe_stage_regs #(.RESET_PC(RST_PC), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .f_predPC(f_predPC), .d_next(d_next), .e_next(e_next),
        .m_next(m_next), .w_next(w_next),
        .F_predPC(F_predPC), .D_q(D_q), .E_q(E_q), .M_q(M_q), .W_q(W_q),
        .halted(halted), .ctrl_err(ctrl_err),
        .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec  = 0;
    int    n_miss = 0;
    snap_t exp_q[$];
    snap_t mdl;

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Quiet cycle with random payloads; writeback status kept AOK.
    function automatic stim_t quiet_stim();
        stim_t s;
        logic [255:0] r;
        s = '0;
        r = rnd256(); s.pc = r[63:0];
        r = rnd256(); s.dn = r[145:0];
        r = rnd256(); s.en = r[217:0];
        r = rnd256(); s.mn = r[142:0];
        r = rnd256(); s.wn = r[141:0];
        s.wn[141:140] = 2'b11;
        return s;
    endfunction

    // Reference model: apply one clock edge of the stage rules to mdl.
    task automatic model_step(input stim_t s);
        if (s.rst) begin
            mdl = '0;
            mdl.pc = RST_PC;
            mdl.d = D_NOP; mdl.e = E_NOP; mdl.m = M_NOP; mdl.w = W_NOP;
        end else begin
            if ((s.ds && s.db) || (s.fs && !s.ds && !s.db)) mdl.err = 1'b1;
            if (!mdl.halted) begin
                if (!s.fs) mdl.pc = s.pc;
                if (!s.ds) mdl.d = s.db ? D_NOP : s.dn;
                mdl.e = s.eb ? E_NOP : s.en;
                mdl.m = s.mb ? M_NOP : s.mn;
                if (s.fs) mdl.sc = mdl.sc + 1'b1;
                if (s.db || s.eb || s.mb) mdl.bc = mdl.bc + 1'b1;
                if (!s.ws) begin
                    mdl.w = s.wn;
                    if (s.wn[141:140] != 2'b11) mdl.halted = 1'b1;
                end
            end
        end
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        rst = s.rst; F_stall = s.fs; D_stall = s.ds; D_bubble = s.db;
        E_bubble = s.eb; M_bubble = s.mb; W_stall = s.ws;
        f_predPC = s.pc; d_next = s.dn; e_next = s.en; m_next = s.mn; w_next = s.wn;
        model_step(s);
        exp_q.push_back(mdl);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        stim_t s;
        s = quiet_stim();
        s.rst = 1'b1;
        applyStimulus(s);
    endtask

    // Monitor: compare every registered output one edge after its stimulus.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("F_predPC", 256'(F_predPC), 256'(e.pc));
                checkOutput("D_q", 256'(D_q), 256'(e.d));
                checkOutput("E_q", 256'(E_q), 256'(e.e));
                checkOutput("M_q", 256'(M_q), 256'(e.m));
                checkOutput("W_q", 256'(W_q), 256'(e.w));
                checkOutput("halted", 256'(halted), 256'(e.halted));
                checkOutput("ctrl_err", 256'(ctrl_err), 256'(e.err));
                checkOutput("stall_cnt", 256'(stall_cnt), 256'(e.sc));
                checkOutput("bubble_cnt", 256'(bubble_cnt), 256'(e.bc));
            end
        end
    end

    initial begin
        stim_t s;
        int    guard;
        mdl = '0;
        rst = 1'b1; F_stall = 0; D_stall = 0; D_bubble = 0; E_bubble = 0;
        M_bubble = 0; W_stall = 0;
        f_predPC = '0; d_next = '0; e_next = '0; m_next = '0; w_next = '0;

        do_reset();
        do_reset();
        settle();
        checkOutput("reset_pc", 256'(F_predPC), 256'(RST_PC));
        checkOutput("reset_d_icode", 256'(D_q[143:140]), 256'(4'h1));

        s = quiet_stim(); s.dn[143:140] = 4'h3;
        applyStimulus(s);
        settle();
        checkOutput("run_d_icode", 256'(D_q[143:140]), 256'(4'h3));

        // Load-use stall: F and D hold, E takes a bubble.
        s = quiet_stim(); s.fs = 1; s.ds = 1; s.eb = 1;
        applyStimulus(s);
        settle();
        checkOutput("loaduse_e_icode", 256'(E_q[215:212]), 256'(4'h1));
        checkOutput("loaduse_e_dst", 256'(E_q[15:8]), 256'(8'hFF));
        checkOutput("loaduse_stall_cnt", 256'(stall_cnt), 256'(1));
        checkOutput("loaduse_bubble_cnt", 256'(bubble_cnt), 256'(1));

        // Mispredict: D and E squashed, M and W keep flowing.
        s = quiet_stim(); s.db = 1; s.eb = 1;
        applyStimulus(s);
        settle();
        checkOutput("mispredict_d", 256'(D_q), 256'(D_NOP));

        s = quiet_stim(); s.ds = 1; s.db = 1;
        applyStimulus(s);
        settle();
        checkOutput("illegal_err", 256'(ctrl_err), 256'(1));
        applyStimulus(quiet_stim());
        do_reset();
        settle();
        checkOutput("reset_clears_err", 256'(ctrl_err), 256'(0));

        // Non-AOK status held off by W_stall must not halt.
        s = quiet_stim(); s.ws = 1; s.wn[141:140] = 2'b01;
        applyStimulus(s);
        settle();
        checkOutput("stalled_adr_no_halt", 256'(halted), 256'(0));

        s = quiet_stim(); s.wn[141:140] = 2'b10;
        applyStimulus(s);
        settle();
        checkOutput("halt_flag", 256'(halted), 256'(1));
        checkOutput("halt_w_stat", 256'(W_q[141:140]), 256'(2'b10));
        for (int i = 0; i < 5; i++) begin
            s = quiet_stim();
            {s.fs, s.ds, s.db, s.eb, s.mb, s.ws} = 6'($urandom);
            applyStimulus(s);
        end
        do_reset();
        settle();
        checkOutput("reset_after_halt", 256'(halted), 256'(0));

        for (int i = 0; i < 17; i++) begin
            s = quiet_stim(); s.fs = 1; s.ds = 1;
            applyStimulus(s);
        end
        settle();
        checkOutput("stall_cnt_wrap", 256'(stall_cnt), 256'(1));

        for (int i = 0; i < 600; i++) begin
            s = quiet_stim();
            s.rst = ($urandom_range(0, 39) == 0);
            s.fs  = ($urandom_range(0, 3) == 0);
            s.ds  = ($urandom_range(0, 3) == 0);
            s.db  = ($urandom_range(0, 4) == 0);
            s.eb  = ($urandom_range(0, 4) == 0);
            s.mb  = ($urandom_range(0, 5) == 0);
            s.ws  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 29) == 0) s.wn[141:140] = 2'($urandom_range(0, 2));
            applyStimulus(s);
        end

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #3;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
